// File: rtl/mor1kx_rf_access_ctrl_pkg.sv
// Shared encodings for the RF access controller: sequencer states and the
// SPR group that maps onto the GPR file.
package mor1kx_rf_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_HOLD  = 3'd4
    } rf_state_e;

    localparam logic [6:0] SPR_GRP_GPR = 7'h2;

    function automatic logic is_gpr_hit(input logic stb, input logic [15:0] addr);
        return stb && (addr[15:9] == SPR_GRP_GPR);
    endfunction

endpackage

// File: rtl/mor1kx_rf_clear_walker.sv
// Address generator for the post-reset RF zero walk; reset always restarts
// the walk from address 0.
module mor1kx_rf_clear_walker #(
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_run,
    output logic [RF_ADDR_WIDTH-1:0] o_addr,
    output logic                     o_done
);

    logic [RF_ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_run) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    // Done is flagged during the cycle that writes the last address.
    assign o_done = i_run && (r_addr == {RF_ADDR_WIDTH{1'b1}});

endmodule

// File: rtl/mor1kx_rf_access_ctrl.sv
// RF write-port arbiter and SPR-side GPR access sequencer: writeback owns the
// write port by default, SPR writes get in on free cycles or by stalling.
module mor1kx_rf_access_ctrl
    import mor1kx_rf_access_ctrl_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int RF_ADDR_WIDTH            = 5,
    parameter int OPTION_RF_CLEAR_ON_RESET = 1,
    parameter int SPR_STARVE_LIMIT         = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_rf_wb_i,
    input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    input  logic                            padv_ctrl_i,
    input  logic [15:0]                     spr_bus_addr_i,
    input  logic                            spr_bus_stb_i,
    input  logic                            spr_bus_we_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
    output logic                            spr_gpr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
    output logic                            rf_wren_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
    output logic                            rf_spr_re_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_spr_rdad_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rf_spr_dout_i,
    output logic                            pipeline_stall_o,
    output logic                            clear_busy_o
);

    localparam rf_state_e  RESET_STATE = (OPTION_RF_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [3:0] STARVE_LIM  = 4'(SPR_STARVE_LIMIT);

    rf_state_e                     r_state;
    rf_state_e                     w_state_next;
    logic [3:0]                    r_starve;
    logic [3:0]                    w_starve_next;
    logic                          r_stall;
    logic                          r_ack;
    logic                          r_resp_wr;
    logic [OPTION_OPERAND_WIDTH-1:0] r_dat;

    logic                            w_hit;
    logic                            w_walk;
    logic                            w_grant;
    logic                            w_lost;
    logic                            w_re;
    logic                            w_wren;
    logic [RF_ADDR_WIDTH-1:0]        w_wradr;
    logic [OPTION_OPERAND_WIDTH-1:0] w_wrdat;
    logic [RF_ADDR_WIDTH-1:0]        w_clr_addr;
    logic                            w_clr_done;

    mor1kx_rf_clear_walker #(
        .RF_ADDR_WIDTH(RF_ADDR_WIDTH)
    ) u_walker (
        .clk    (clk),
        .rst    (rst),
        .i_run  (w_walk),
        .o_addr (w_clr_addr),
        .o_done (w_clr_done)
    );

    assign w_hit = is_gpr_hit(spr_bus_stb_i, spr_bus_addr_i);

    always_comb begin
        w_state_next = r_state;
        w_wren       = wb_rf_wb_i;
        w_wradr      = wb_rfd_adr_i;
        w_wrdat      = result_i;
        w_re         = 1'b0;
        w_grant      = 1'b0;
        w_lost       = 1'b0;
        w_walk       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_walk  = 1'b1;
                w_wren  = 1'b1;
                w_wradr = w_clr_addr;
                w_wrdat = '0;
                if (w_clr_done) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_hit && spr_bus_we_i) begin
                    if (!wb_rf_wb_i) begin
                        w_grant      = 1'b1;
                        w_wren       = 1'b1;
                        w_wradr      = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
                        w_wrdat      = spr_bus_dat_i;
                        w_state_next = ST_RESP;
                    end else begin
                        w_lost = 1'b1;
                    end
                end else if (w_hit && !padv_ctrl_i) begin
                    w_re         = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_HOLD;
            ST_HOLD: if (!spr_bus_stb_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Starve counter saturates at the limit; any idle cycle without a lost
    // write (grant, abort or no request) clears it.
    always_comb begin
        w_starve_next = r_starve;
        if (w_lost) begin
            if (r_starve < STARVE_LIM) w_starve_next = r_starve + 4'd1;
        end else if (r_state == ST_IDLE) begin
            w_starve_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RESET_STATE;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_ack     <= 1'b0;
            r_resp_wr <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_starve  <= w_starve_next;
            r_stall   <= (w_starve_next >= STARVE_LIM);
            r_ack     <= (w_state_next == ST_RESP);
            r_resp_wr <= w_grant;
            if (r_state == ST_READ) r_dat <= rf_spr_dout_i;
        end
    end

    assign rf_wren_o        = w_wren & ~rst;
    assign rf_wradr_o       = w_wradr;
    assign rf_wrdat_o       = w_wrdat;
    assign rf_spr_re_o      = w_re & ~rst;
    assign rf_spr_rdad_o    = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
    assign spr_gpr_ack_o    = r_ack & ~rst;
    assign spr_gpr_dat_o    = (r_ack && r_resp_wr) ? '0 : r_dat;
    assign pipeline_stall_o = (r_state == ST_CLEAR) | r_stall;
    assign clear_busy_o     = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_mor1kx_rf_access_ctrl.sv
// Bench for the RF access controller: directed scenarios plus a randomized
// op mix checked against an array model of the register file.
module tb_mor1kx_rf_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_rf_wb_i = 1'b0;
    logic [AW-1:0] wb_rfd_adr_i = '0;
    logic [DW-1:0] result_i = '0;
    logic          padv_ctrl_i = 1'b0;
    logic [15:0]   spr_bus_addr_i = '0;
    logic          spr_bus_stb_i = 1'b0;
    logic          spr_bus_we_i = 1'b0;
    logic [DW-1:0] spr_bus_dat_i = '0;
    logic          spr_gpr_ack_o;
    logic [DW-1:0] spr_gpr_dat_o;
    logic          rf_wren_o;
    logic [AW-1:0] rf_wradr_o;
    logic [DW-1:0] rf_wrdat_o;
    logic          rf_spr_re_o;
    logic [AW-1:0] rf_spr_rdad_o;
    logic [DW-1:0] rf_spr_dout_i;
    logic          pipeline_stall_o;
    logic          clear_busy_o;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [NREG];
    logic [DW-1:0] exp_rf [NREG];

    mor1kx_rf_access_ctrl #(
        .OPTION_OPERAND_WIDTH    (DW),
        .RF_ADDR_WIDTH           (AW),
        .OPTION_RF_CLEAR_ON_RESET(1),
        .SPR_STARVE_LIMIT        (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_rf_wb_i      (wb_rf_wb_i),
        .wb_rfd_adr_i    (wb_rfd_adr_i),
        .result_i        (result_i),
        .padv_ctrl_i     (padv_ctrl_i),
        .spr_bus_addr_i  (spr_bus_addr_i),
        .spr_bus_stb_i   (spr_bus_stb_i),
        .spr_bus_we_i    (spr_bus_we_i),
        .spr_bus_dat_i   (spr_bus_dat_i),
        .spr_gpr_ack_o   (spr_gpr_ack_o),
        .spr_gpr_dat_o   (spr_gpr_dat_o),
        .rf_wren_o       (rf_wren_o),
        .rf_wradr_o      (rf_wradr_o),
        .rf_wrdat_o      (rf_wrdat_o),
        .rf_spr_re_o     (rf_spr_re_o),
        .rf_spr_rdad_o   (rf_spr_rdad_o),
        .rf_spr_dout_i   (rf_spr_dout_i),
        .pipeline_stall_o(pipeline_stall_o),
        .clear_busy_o    (clear_busy_o)
    );

    always #5 clk = ~clk;

    // RF RAM stand-in: one write port, one registered SPR read port.
    always @(posedge clk) begin
        if (rf_wren_o) mem[rf_wradr_o] <= rf_wrdat_o;
        if (rf_spr_re_o) rf_spr_dout_i <= mem[rf_spr_rdad_o];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        wb_rf_wb_i = 1'b0;
        spr_bus_stb_i = 1'b0;
        spr_bus_we_i = 1'b0;
        padv_ctrl_i = 1'b0;
    endtask

    // Release strobe and let the sequencer pass RESP/HOLD back to idle.
    task automatic end_access();
        idle_bus();
        step();
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rf_wren_o !== 1'b0 || rf_spr_re_o !== 1'b0 || spr_gpr_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: wren=%b re=%b ack=%b, required 0/0/0", rf_wren_o, rf_spr_re_o, spr_gpr_ack_o);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (rf_wren_o !== 1'b1 || rf_wradr_o !== AW'(i) || rf_wrdat_o !== '0 ||
                pipeline_stall_o !== 1'b1 || clear_busy_o !== 1'b1) begin
                failures++;
                $display("FAIL clear_walk[%0d]: wren=%b adr=%0d dat=%h stall=%b busy=%b, required 1/%0d/0/1/1",
                         i, rf_wren_o, rf_wradr_o, rf_wrdat_o, pipeline_stall_o, clear_busy_o, i);
            end
            step();
        end
        checks++;
        if (clear_busy_o !== 1'b0 || pipeline_stall_o !== 1'b0 || rf_wren_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_done: busy=%b stall=%b wren=%b, required 0/0/0", clear_busy_o, pipeline_stall_o, rf_wren_o);
        end
        for (int i = 0; i < NREG; i++) exp_rf[i] = '0;
    endtask

    task automatic test_spr_write();
        spr_bus_addr_i = 16'h0405;
        spr_bus_dat_i = 32'hDEADBEEF;
        spr_bus_we_i = 1'b1;
        spr_bus_stb_i = 1'b1;
        #1;
        checks++;
        if (rf_wren_o !== 1'b1 || rf_wradr_o !== 5'd5 || rf_wrdat_o !== 32'hDEADBEEF || spr_gpr_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL spr_write_grant: wren=%b adr=%0d dat=%h ack=%b, required 1/5/deadbeef/0",
                     rf_wren_o, rf_wradr_o, rf_wrdat_o, spr_gpr_ack_o);
        end
        step();
        checks++;
        if (spr_gpr_ack_o !== 1'b1 || spr_gpr_dat_o !== '0 || rf_wren_o !== 1'b0) begin
            failures++;
            $display("FAIL spr_write_ack: ack=%b dat=%h wren=%b, required 1/0/0", spr_gpr_ack_o, spr_gpr_dat_o, rf_wren_o);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (spr_gpr_ack_o !== 1'b0 || rf_wren_o !== 1'b0) begin
                failures++;
                $display("FAIL spr_write_held[%0d]: ack=%b wren=%b, required 0/0", k, spr_gpr_ack_o, rf_wren_o);
            end
        end
        end_access();
        exp_rf[5] = 32'hDEADBEEF;
        checks++;
        if (mem[5] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL spr_write_rf: RF[5]=%h, required deadbeef", mem[5]);
        end
    endtask

    task automatic test_spr_read();
        wb_rf_wb_i = 1'b1;
        wb_rfd_adr_i = 5'd3;
        result_i = 32'h12345678;
        step();
        wb_rf_wb_i = 1'b0;
        exp_rf[3] = 32'h12345678;
        spr_bus_addr_i = 16'h0403;
        spr_bus_we_i = 1'b0;
        spr_bus_stb_i = 1'b1;
        #1;
        checks++;
        if (rf_spr_re_o !== 1'b1 || rf_spr_rdad_o !== 5'd3) begin
            failures++;
            $display("FAIL spr_read_re: re=%b rdad=%0d, required 1/3", rf_spr_re_o, rf_spr_rdad_o);
        end
        step();
        checks++;
        if (spr_gpr_ack_o !== 1'b0 || rf_spr_re_o !== 1'b0) begin
            failures++;
            $display("FAIL spr_read_cycle1: ack=%b re=%b, required 0/0", spr_gpr_ack_o, rf_spr_re_o);
        end
        step();
        checks++;
        if (spr_gpr_ack_o !== 1'b1 || spr_gpr_dat_o !== 32'h12345678) begin
            failures++;
            $display("FAIL spr_read_ack: ack=%b dat=%h, required 1/12345678", spr_gpr_ack_o, spr_gpr_dat_o);
        end
        end_access();
        checks++;
        if (spr_gpr_dat_o !== 32'h12345678) begin
            failures++;
            $display("FAIL spr_read_hold_dat: dat=%h, required 12345678", spr_gpr_dat_o);
        end
    endtask

    task automatic test_starve();
        wb_rf_wb_i = 1'b1;
        wb_rfd_adr_i = 5'd9;
        result_i = 32'hA5A5_0009;
        spr_bus_addr_i = 16'h040A;
        spr_bus_dat_i = 32'hCAFE_000A;
        spr_bus_we_i = 1'b1;
        spr_bus_stb_i = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (pipeline_stall_o !== 1'b0 || rf_wradr_o !== 5'd9 || spr_gpr_ack_o !== 1'b0) begin
                failures++;
                $display("FAIL starve_lost[%0d]: stall=%b adr=%0d ack=%b, required 0/9/0", k, pipeline_stall_o, rf_wradr_o, spr_gpr_ack_o);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pipeline_stall_o !== 1'b1) begin
                failures++;
                $display("FAIL starve_stall[%0d]: stall=%b, required 1", k, pipeline_stall_o);
            end
            step();
        end
        exp_rf[9] = 32'hA5A5_0009;
        wb_rf_wb_i = 1'b0;
        #1;
        checks++;
        if (rf_wren_o !== 1'b1 || rf_wradr_o !== 5'd10 || rf_wrdat_o !== 32'hCAFE_000A || pipeline_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL starve_grant: wren=%b adr=%0d dat=%h stall=%b, required 1/10/cafe000a/1",
                     rf_wren_o, rf_wradr_o, rf_wrdat_o, pipeline_stall_o);
        end
        step();
        checks++;
        if (spr_gpr_ack_o !== 1'b1 || pipeline_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL starve_release: ack=%b stall=%b, required 1/0", spr_gpr_ack_o, pipeline_stall_o);
        end
        end_access();
        exp_rf[10] = 32'hCAFE_000A;
    endtask

    task automatic test_same_addr();
        wb_rf_wb_i = 1'b1;
        wb_rfd_adr_i = 5'd7;
        result_i = 32'h1;
        spr_bus_addr_i = 16'h0407;
        spr_bus_dat_i = 32'h2;
        spr_bus_we_i = 1'b1;
        spr_bus_stb_i = 1'b1;
        #1;
        checks++;
        if (rf_wren_o !== 1'b1 || rf_wradr_o !== 5'd7 || rf_wrdat_o !== 32'h1) begin
            failures++;
            $display("FAIL same_addr_wb: wren=%b adr=%0d dat=%h, required 1/7/1", rf_wren_o, rf_wradr_o, rf_wrdat_o);
        end
        step();
        wb_rf_wb_i = 1'b0;
        #1;
        checks++;
        if (rf_wren_o !== 1'b1 || rf_wradr_o !== 5'd7 || rf_wrdat_o !== 32'h2) begin
            failures++;
            $display("FAIL same_addr_spr: wren=%b adr=%0d dat=%h, required 1/7/2", rf_wren_o, rf_wradr_o, rf_wrdat_o);
        end
        step();
        end_access();
        exp_rf[7] = 32'h2;
        checks++;
        if (mem[7] !== 32'h2) begin
            failures++;
            $display("FAIL same_addr_final: RF[7]=%h, required 2", mem[7]);
        end
    endtask

    task automatic test_rst_mid_clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (17) step();
        checks++;
        if (rf_wradr_o !== 5'd17 || clear_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midclear_pos: adr=%0d busy=%b, required 17/1", rf_wradr_o, clear_busy_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rf_wren_o !== 1'b0 || rf_spr_re_o !== 1'b0 || spr_gpr_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL midclear_async: wren=%b re=%b ack=%b, required 0/0/0", rf_wren_o, rf_spr_re_o, spr_gpr_ack_o);
        end
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (rf_wren_o !== 1'b1 || rf_wradr_o !== AW'(i) || rf_wrdat_o !== '0) begin
                failures++;
                $display("FAIL midclear_walk[%0d]: wren=%b adr=%0d dat=%h, required 1/%0d/0", i, rf_wren_o, rf_wradr_o, rf_wrdat_o, i);
            end
            step();
        end
        checks++;
        if (clear_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL midclear_done: busy=%b, required 0", clear_busy_o);
        end
        for (int i = 0; i < NREG; i++) exp_rf[i] = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int op;
            int lat;
            int waits;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [6:0] grp;
            op = $urandom_range(0, 3);
            a = AW'($urandom);
            d = $urandom;
            if (op == 0) begin
                wb_rf_wb_i = 1'b1;
                wb_rfd_adr_i = a;
                result_i = d;
                exp_rf[a] = d;
                step();
                idle_bus();
            end else if (op == 1) begin
                waits = $urandom_range(0, 3);
                spr_bus_addr_i = {7'h2, 4'($urandom), a};
                spr_bus_dat_i = d;
                spr_bus_we_i = 1'b1;
                spr_bus_stb_i = 1'b1;
                for (int k = 0; k < waits; k++) begin
                    logic [AW-1:0] wa;
                    logic [DW-1:0] wd;
                    wa = AW'($urandom);
                    wd = $urandom;
                    wb_rf_wb_i = 1'b1;
                    wb_rfd_adr_i = wa;
                    result_i = wd;
                    exp_rf[wa] = wd;
                    step();
                end
                wb_rf_wb_i = 1'b0;
                lat = 0;
                while (spr_gpr_ack_o !== 1'b1 && lat < 8) begin
                    step();
                    lat++;
                end
                checks++;
                if (lat != 1 || spr_gpr_dat_o !== '0) begin
                    failures++;
                    $display("FAIL rand_write[%0d]: latency=%0d dat=%h after %0d lost, required 1/0", n, lat, spr_gpr_dat_o, waits);
                end
                exp_rf[a] = d;
                end_access();
            end else if (op == 2) begin
                waits = $urandom_range(0, 3);
                spr_bus_addr_i = {7'h2, 4'($urandom), a};
                spr_bus_we_i = 1'b0;
                spr_bus_stb_i = 1'b1;
                padv_ctrl_i = 1'b1;
                repeat (waits) step();
                padv_ctrl_i = 1'b0;
                lat = waits;
                while (spr_gpr_ack_o !== 1'b1 && lat < waits + 8) begin
                    step();
                    lat++;
                end
                checks++;
                if (lat != waits + 2 || spr_gpr_dat_o !== exp_rf[a]) begin
                    failures++;
                    $display("FAIL rand_read[%0d]: r%0d latency=%0d dat=%h, required %0d/%h", n, a, lat, spr_gpr_dat_o, waits + 2, exp_rf[a]);
                end
                end_access();
            end else begin
                grp = 7'($urandom);
                if (grp == 7'h2) grp = 7'h3;
                spr_bus_addr_i = {grp, 4'($urandom), a};
                spr_bus_dat_i = d;
                spr_bus_we_i = 1'($urandom);
                spr_bus_stb_i = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    checks++;
                    if (spr_gpr_ack_o !== 1'b0 || rf_wren_o !== 1'b0 || rf_spr_re_o !== 1'b0) begin
                        failures++;
                        $display("FAIL rand_nonhit[%0d]: grp=%h ack=%b wren=%b re=%b, required 0/0/0", n, grp, spr_gpr_ack_o, rf_wren_o, rf_spr_re_o);
                    end
                    step();
                end
                idle_bus();
                step();
            end
        end
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (mem[i] !== exp_rf[i]) begin
                failures++;
                $display("FAIL rand_rf[%0d]: got %h, required %h", i, mem[i], exp_rf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spr_write();
        test_spr_read();
        test_starve();
        test_same_addr();
        test_rst_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
